// File: rtl/sp_bus_pkg.sv
// Shared definitions for the 8-bit to 32-bit Wishbone bridge: FSM states,
// bus widths and big-endian byte-lane helpers (lane 0 = bits [0:7]).
package sp_bus_pkg;

  localparam int BADR_W = 24;
  localparam int WADR_W = 22;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MREQ = 2'd1,
    ST_SACK = 2'd2
  } state_e;

  function automatic logic [0:7] lane_sel(input logic [0:31] w, input logic [0:1] off);
    logic [0:7] b;
    case (off)
      2'd0:    b = w[0:7];
      2'd1:    b = w[8:15];
      2'd2:    b = w[16:23];
      default: b = w[24:31];
    endcase
    return b;
  endfunction

  function automatic logic [0:3] lane_to_sel(input logic [0:1] off);
    logic [0:3] s;
    s = '0;
    s[off] = 1'b1;
    return s;
  endfunction

  function automatic logic [0:31] lane_put(input logic [0:31] w, input logic [0:1] off,
                                           input logic [0:7] b);
    logic [0:31] r;
    r = w;
    case (off)
      2'd0:    r[0:7]   = b;
      2'd1:    r[8:15]  = b;
      2'd2:    r[16:23] = b;
      default: r[24:31] = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wb8_to_wb32.sv
// Bridges an 8-bit Wishbone slave port onto a 32-bit big-endian Wishbone master.
// Define WB8_TO_WB32_RDCACHE_EN to add a one-word write-through read buffer.
module wb8_to_wb32
  import sp_bus_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [0:BADR_W-1] s_adr_i,
  input  logic [0:7]        s_dat_i,
  output logic [0:7]        s_dat_o,
  input  logic              s_we_i,
  input  logic [0:0]        s_sel_i,
  input  logic              s_stb_i,
  input  logic              s_cyc_i,
  output logic              s_ack_o,
  output logic [0:WADR_W-1] m_adr_o,
  output logic [0:31]       m_dat_o,
  input  logic [0:31]       m_dat_i,
  output logic [0:3]        m_sel_o,
  output logic              m_we_o,
  output logic              m_stb_o,
  output logic              m_cyc_o,
  input  logic              m_ack_i,
  input  logic              inv_i
);

  state_e              state_q, state_d;
  logic                abort_q, abort_d;
  logic [0:1]          off_q, off_d;
  logic                s_ack_q;
  logic [0:7]          s_dat_q, s_dat_d;
  logic                m_cyc_q, m_cyc_d;
  logic [0:WADR_W-1]   m_adr_q, m_adr_d;
  logic [0:31]         m_dat_q, m_dat_d;
  logic [0:3]          m_sel_q, m_sel_d;
  logic                m_we_q, m_we_d;
  logic                accept, fill, wr_done, hit;
  logic [0:7]          buf_rd;

  assign accept = s_cyc_i && s_stb_i;

  always_comb begin
    state_d = state_q;
    abort_d = abort_q;
    off_d   = off_q;
    s_dat_d = s_dat_q;
    m_cyc_d = m_cyc_q;
    m_adr_d = m_adr_q;
    m_dat_d = m_dat_q;
    m_sel_d = m_sel_q;
    m_we_d  = m_we_q;
    fill    = 1'b0;
    wr_done = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          off_d   = s_adr_i[22:23];
          abort_d = 1'b0;
          if (s_we_i && !s_sel_i[0]) begin
            state_d = ST_SACK;
          end else if (!s_we_i && hit) begin
            state_d = ST_SACK;
            s_dat_d = buf_rd;
          end else begin
            state_d = ST_MREQ;
            m_cyc_d = 1'b1;
            m_adr_d = s_adr_i[0:WADR_W-1];
            m_we_d  = s_we_i;
            m_sel_d = s_we_i ? lane_to_sel(s_adr_i[22:23]) : 4'b1111;
            m_dat_d = {4{s_dat_i}};
          end
        end
      end
      ST_MREQ: begin
        if (!s_cyc_i) abort_d = 1'b1;
        if (m_ack_i) begin
          m_cyc_d = 1'b0;
          fill    = !m_we_q;
          wr_done = m_we_q;
          if (!m_we_q) s_dat_d = lane_sel(m_dat_i, off_q);
          // An abandoned slave cycle finishes on the master side silently.
          state_d = (abort_q || !s_cyc_i) ? ST_IDLE : ST_SACK;
        end
      end
      ST_SACK: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      abort_q <= 1'b0;
      s_ack_q <= 1'b0;
      s_dat_q <= '0;
      m_cyc_q <= 1'b0;
      m_adr_q <= '0;
      m_dat_q <= '0;
      m_sel_q <= '0;
      m_we_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      abort_q <= abort_d;
      s_ack_q <= (state_d == ST_SACK);
      s_dat_q <= s_dat_d;
      m_cyc_q <= m_cyc_d;
      m_adr_q <= m_adr_d;
      m_dat_q <= m_dat_d;
      m_sel_q <= m_sel_d;
      m_we_q  <= m_we_d;
    end
  end

  always_ff @(posedge clk) begin
    off_q <= off_d;
  end

`ifdef WB8_TO_WB32_RDCACHE_EN
  logic              buf_vld_q;
  logic [0:WADR_W-1] buf_tag_q;
  logic [0:31]       buf_dat_q;

  assign hit    = buf_vld_q && (buf_tag_q == s_adr_i[0:WADR_W-1]);
  assign buf_rd = lane_sel(buf_dat_q, s_adr_i[22:23]);

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_vld_q <= 1'b0;
    end else if (inv_i) begin
      buf_vld_q <= 1'b0;
    end else if (fill) begin
      buf_vld_q <= 1'b1;
    end
  end

  // Written byte is lane 0 of m_dat_q since the write byte is replicated.
  always_ff @(posedge clk) begin
    if (fill) begin
      buf_tag_q <= m_adr_q;
      buf_dat_q <= m_dat_i;
    end else if (wr_done && buf_vld_q && (buf_tag_q == m_adr_q)) begin
      buf_dat_q <= lane_put(buf_dat_q, off_q, m_dat_q[0:7]);
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{inv_i, fill, wr_done};
  assign hit        = 1'b0;
  assign buf_rd     = '0;
`endif

  assign s_ack_o = s_ack_q;
  assign s_dat_o = s_dat_q;
  assign m_cyc_o = m_cyc_q;
  assign m_stb_o = m_cyc_q;
  assign m_adr_o = m_adr_q;
  assign m_dat_o = m_dat_q;
  assign m_sel_o = m_sel_q;
  assign m_we_o  = m_we_q;

endmodule

// File: tb/tb_wb8_to_wb32.sv
// Self-checking bench for wb8_to_wb32 against a transaction-level bridge model;
// honours WB8_TO_WB32_RDCACHE_EN for the read buffer expectations.
module tb_wb8_to_wb32;

`ifdef WB8_TO_WB32_RDCACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] s_adr_i;
  logic [7:0]  s_dat_i, s_dat_o;
  logic        s_we_i;
  logic [0:0]  s_sel_i;
  logic        s_stb_i, s_cyc_i, s_ack_o;
  logic [21:0] m_adr_o;
  logic [31:0] m_dat_o, m_dat_i;
  logic [3:0]  m_sel_o;
  logic        m_we_o, m_stb_o, m_cyc_o, m_ack_i, inv_i;

  int n_chk = 0;
  int n_pass = 0;

  // model state: the single buffered word
  bit          cvalid = 1'b0;
  logic [21:0] ctag = '0;
  logic [31:0] cword = '0;

  // expectations for the current transaction, used by the compare process
  bit          mon_en = 1'b0;
  logic [21:0] e_adr;
  logic [3:0]  e_sel;
  bit          e_we;
  logic [31:0] e_mdat;
  logic [7:0]  e_sdat;

  // observations from the last transaction
  logic [21:0] obs_adr;
  logic [3:0]  obs_sel;
  logic        obs_we;
  logic [31:0] obs_mdat;
  logic [7:0]  obs_sdat;
  int          obs_ncyc, obs_nack, obs_first;

  always #5 clk = ~clk;

  wb8_to_wb32 dut (
    .clk(clk), .reset(reset),
    .s_adr_i(s_adr_i), .s_dat_i(s_dat_i), .s_dat_o(s_dat_o), .s_we_i(s_we_i),
    .s_sel_i(s_sel_i), .s_stb_i(s_stb_i), .s_cyc_i(s_cyc_i), .s_ack_o(s_ack_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_sel_o(m_sel_o),
    .m_we_o(m_we_o), .m_stb_o(m_stb_o), .m_cyc_o(m_cyc_o), .m_ack_i(m_ack_i),
    .inv_i(inv_i)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  function automatic logic [7:0] lane(input logic [31:0] w, input logic [1:0] o);
    return w[31-8*o -: 8];
  endfunction

  always @(negedge clk) begin
    if (!reset && mon_en) begin
      if (m_cyc_o) begin
        chk("m_stb", 32'(m_stb_o), 32'd1);
        chk("m_adr", 32'(m_adr_o), 32'(e_adr));
        chk("m_sel", 32'(m_sel_o), 32'(e_sel));
        chk("m_we", 32'(m_we_o), 32'(e_we));
        if (e_we) chk("m_dat", m_dat_o, e_mdat);
      end
      if (s_ack_o && !e_we) chk("s_dat", 32'(s_dat_o), 32'(e_sdat));
    end
  end

  task automatic do_txn(input bit we, input logic [23:0] a, input logic [7:0] d, input bit sel,
                        input int waits, input bit drop, input bit inv_at_ack,
                        input logic [31:0] rdata);
    logic [21:0] w;
    logic [1:0]  off;
    bit          hit, need_m, inv_hit;
    int          ack_k;
    w       = a[23:2];
    off     = a[1:0];
    hit     = CACHE && !we && cvalid && (ctag == w);
    need_m  = we ? sel : !hit;
    e_adr   = w;
    e_we    = we;
    e_sel   = we ? (4'b1000 >> off) : 4'b1111;
    e_mdat  = {4{d}};
    e_sdat  = hit ? lane(cword, off) : lane(rdata, off);
    inv_hit = 1'b0;
    obs_ncyc = 0; obs_nack = 0; obs_first = -1; ack_k = -1;
    obs_adr = '0; obs_sel = '0; obs_we = 1'b0; obs_mdat = '0; obs_sdat = '0;
    @(negedge clk);
    s_adr_i = a; s_dat_i = d; s_we_i = we; s_sel_i = sel;
    s_cyc_i = 1'b1; s_stb_i = 1'b1; mon_en = 1'b1;
    for (int k = 1; k <= waits + 12; k++) begin
      @(negedge clk);
      if (m_ack_i) begin
        m_ack_i = 1'b0;
        if (inv_i) begin inv_i = 1'b0; inv_hit = 1'b1; end
      end
      if (m_cyc_o) begin
        if (obs_ncyc == 0) begin
          obs_adr = m_adr_o; obs_sel = m_sel_o; obs_we = m_we_o; obs_mdat = m_dat_o;
        end
        obs_ncyc++;
      end
      if (s_ack_o) begin
        obs_nack++;
        if (obs_first < 0) begin obs_first = k; obs_sdat = s_dat_o; end
        s_cyc_i = 1'b0; s_stb_i = 1'b0;
      end
      if (drop && k == 1) begin s_cyc_i = 1'b0; s_stb_i = 1'b0; end
      if (m_cyc_o && ack_k < 0 && k == 1 + waits) begin
        m_ack_i = 1'b1; m_dat_i = rdata; ack_k = k;
        if (inv_at_ack) inv_i = 1'b1;
      end
    end
    s_cyc_i = 1'b0; s_stb_i = 1'b0; m_ack_i = 1'b0; inv_i = 1'b0;
    mon_en = 1'b0;
    chk("m_cyc_len", 32'(obs_ncyc), need_m ? 32'(1 + waits) : 32'd0);
    chk("s_ack_count", 32'(obs_nack), (drop && need_m) ? 32'd0 : 32'd1);
    if (!(drop && need_m))
      chk("s_ack_latency", 32'(obs_first), need_m ? 32'(2 + waits) : 32'd1);
    if (need_m && !we) begin
      cvalid = !inv_hit; ctag = w; cword = rdata;
    end
    if (we && sel && cvalid && ctag == w) cword[31-8*off -: 8] = d;
  endtask

  task automatic inv_pulse();
    @(negedge clk); inv_i = 1'b1;
    @(negedge clk); inv_i = 1'b0;
    cvalid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_ack"}, 32'(s_ack_o), 32'd0);
    chk({tag, "_m_cyc"}, 32'(m_cyc_o), 32'd0);
    chk({tag, "_m_stb"}, 32'(m_stb_o), 32'd0);
    chk({tag, "_m_we"}, 32'(m_we_o), 32'd0);
    chk({tag, "_m_sel"}, 32'(m_sel_o), 32'd0);
    chk({tag, "_m_adr"}, 32'(m_adr_o), 32'd0);
    chk({tag, "_m_dat"}, m_dat_o, 32'd0);
    chk({tag, "_s_dat"}, 32'(s_dat_o), 32'd0);
  endtask

  initial begin
    reset = 1'b1; s_adr_i = '0; s_dat_i = '0; s_we_i = 1'b0; s_sel_i = 1'b0;
    s_stb_i = 1'b0; s_cyc_i = 1'b0; m_dat_i = '0; m_ack_i = 1'b0; inv_i = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;

    // single-byte read through the master, 3 wait cycles
    do_txn(1'b0, 24'h001002, 8'h00, 1'b1, 3, 1'b0, 1'b0, 32'h11223344);
    chk("rd_adr", 32'(obs_adr), 32'h000400);
    chk("rd_sel", 32'(obs_sel), 32'hF);
    chk("rd_sdat", 32'(obs_sdat), 32'h33);

    do_txn(1'b0, 24'h001000, 8'h00, 1'b1, 2, 1'b0, 1'b0, 32'hDEADBEEF);
    if (CACHE) begin
      chk("hit_sdat", 32'(obs_sdat), 32'h11);
      chk("hit_ncyc", 32'(obs_ncyc), 32'd0);
    end
    inv_pulse();
    do_txn(1'b0, 24'h001000, 8'h00, 1'b1, 2, 1'b0, 1'b0, 32'h55667788);
    chk("inv_ncyc", 32'(obs_ncyc), 32'd3);
    chk("inv_sdat", 32'(obs_sdat), 32'h55);

    // byte write, then read it back from the buffer
    do_txn(1'b1, 24'h001003, 8'hAB, 1'b1, 1, 1'b0, 1'b0, 32'h0);
    chk("wr_we", 32'(obs_we), 32'd1);
    chk("wr_sel", 32'(obs_sel), 32'h1);
    chk("wr_mdat", obs_mdat, 32'hABABABAB);
    do_txn(1'b0, 24'h001003, 8'h00, 1'b1, 1, 1'b0, 1'b0, 32'h0);
    if (CACHE) begin
      chk("wt_sdat", 32'(obs_sdat), 32'hAB);
      chk("wt_ncyc", 32'(obs_ncyc), 32'd0);
    end

    // write with no byte selected
    do_txn(1'b1, 24'h002000, 8'h5A, 1'b0, 0, 1'b0, 1'b0, 32'h0);
    chk("sel0_first", 32'(obs_first), 32'd1);
    chk("sel0_ncyc", 32'(obs_ncyc), 32'd0);

    // slave abandons the cycle while the master is waiting
    do_txn(1'b0, 24'h003001, 8'h00, 1'b1, 4, 1'b1, 1'b0, 32'hCAFEF00D);
    chk("drop_nack", 32'(obs_nack), 32'd0);
    chk("drop_ncyc", 32'(obs_ncyc), 32'd5);

    // reset in the middle of a master cycle, then a stray late ack
    @(negedge clk);
    s_adr_i = 24'h004000; s_we_i = 1'b0; s_sel_i = 1'b1; s_cyc_i = 1'b1; s_stb_i = 1'b1;
    @(negedge clk);
    chk("pre_reset_m_cyc", 32'(m_cyc_o), 32'd1);
    reset = 1'b1; s_cyc_i = 1'b0; s_stb_i = 1'b0;
    @(negedge clk);
    chk_all_zero("mid_reset");
    reset = 1'b0; m_ack_i = 1'b1; m_dat_i = 32'h99999999;
    cvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      m_ack_i = 1'b0;
      chk("late_ack_m_cyc", 32'(m_cyc_o), 32'd0);
      chk("late_ack_s_ack", 32'(s_ack_o), 32'd0);
    end

    // invalidate coincident with a fill
    do_txn(1'b0, 24'h005002, 8'h00, 1'b1, 1, 1'b0, 1'b1, 32'h01020304);
    do_txn(1'b0, 24'h005002, 8'h00, 1'b1, 0, 1'b0, 1'b0, 32'hA0B0C0D0);
    chk("inv_fill_ncyc", 32'(obs_ncyc), 32'd1);

    // randomized traffic over a small set of words so the buffer gets hit
    for (int t = 0; t < 300; t++) begin
      logic [23:0] a;
      bit          we, sel, drop, iack;
      a    = 24'h010000 | 24'(($urandom_range(0, 5) << 2) | $urandom_range(0, 3));
      we   = ($urandom_range(0, 2) == 0);
      sel  = ($urandom_range(0, 5) != 0);
      drop = ($urandom_range(0, 9) == 0);
      iack = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) inv_pulse();
      do_txn(we, a, 8'($urandom), sel, $urandom_range(0, 4), drop, iack, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
